// File: rtl/lbp_pkg.sv
// -----------------------------------------------------------------------------
// lbp_pkg
// Shared constants, FSM state type and helpers for the LBP host memory.
//   IMG_W, IMG_H : image geometry (powers of two)
//   DW           : pixel width (gray and lbp)
//   AW           : address width, log2(IMG_W*IMG_H)
//   is_border()  : true for row 0, row IMG_H-1, col 0 and col IMG_W-1
// -----------------------------------------------------------------------------
package lbp_pkg;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int DW    = 8;
    localparam int AW    = 14;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = AW - XW;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SERVE = 3'd2,
        DUMP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Raster address splits cleanly into row/col because IMG_W is a power of two.
    function automatic logic is_border(input logic [AW-1:0] addr);
        logic [XW-1:0] col;
        logic [YW-1:0] row;
        col = addr[XW-1:0];
        row = addr[AW-1:XW];
        return (row == '0) || (row == YW'(IMG_H - 1)) ||
               (col == '0) || (col == XW'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/lbp_sram.sv
// -----------------------------------------------------------------------------
// lbp_sram
// DW x 2**AW storage with one synchronous write port and one asynchronous
// read port. Contents are not reset.
//   i_clk            : write clock
//   i_we/i_waddr/i_wdata : write port, committed on rising edge
//   i_raddr/o_rdata  : combinational read port
// -----------------------------------------------------------------------------
module lbp_sram #(
    parameter int DW = 8,
    parameter int AW = 14
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lbp_host_mem.sv
// -----------------------------------------------------------------------------
// lbp_host_mem
// Host-side memory responder for the LBP engine: loads the gray image from a
// stream, serves same-cycle gray reads, captures lbp writes, then streams the
// result image out under valid/ready.
//   clk, reset                 : clock, async active-high reset
//   start                      : begin load (IDLE only)
//   in_valid/in_data/in_ready  : gray image load stream, raster order
//   gray_ready                 : gray image loaded, engine may read
//   gray_addr/gray_data        : engine read port, combinational
//   lbp_valid/lbp_addr/lbp_data: engine result write port
//   finish                     : engine has completed all writes
//   out_valid/out_addr/out_data/out_ready : result stream
//   done                       : result fully delivered, sticky until reset
// Build option: LBP_BORDER_CLEAR_EN forces out_data to 0 on border pixels.
//
// state | meaning
// IDLE  | waiting for start, all outputs 0
// LOAD  | accepting gray pixels into gray_mem
// SERVE | engine reads gray_mem and writes lbp_mem
// DUMP  | streaming lbp_mem out
// DONE  | result delivered, only reset leaves
// -----------------------------------------------------------------------------
module lbp_host_mem
    import lbp_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          gray_ready,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          done
);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_ld_cnt;
    logic [AW-1:0] r_dp_cnt;
    logic          w_ld_acc;
    logic          w_dp_acc;
    logic          w_lbp_we;
    logic [DW-1:0] w_gray_rdata;
    logic [DW-1:0] w_lbp_rdata;

    assign w_ld_acc = (r_state == LOAD)  && in_valid;
    assign w_dp_acc = (r_state == DUMP)  && out_ready;
    assign w_lbp_we = (r_state == SERVE) && lbp_valid;

    lbp_sram #(.DW(DW), .AW(AW)) u_gray_mem (
        .i_clk   (clk),
        .i_we    (w_ld_acc),
        .i_waddr (r_ld_cnt),
        .i_wdata (in_data),
        .i_raddr (gray_addr),
        .o_rdata (w_gray_rdata)
    );

    lbp_sram #(.DW(DW), .AW(AW)) u_lbp_mem (
        .i_clk   (clk),
        .i_we    (w_lbp_we),
        .i_waddr (lbp_addr),
        .i_wdata (lbp_data),
        .i_raddr (r_dp_cnt),
        .o_rdata (w_lbp_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A write coinciding with finish still lands: the lbp write enable is
    // decoded from the current state, which is SERVE on that edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    if (w_ld_acc && (r_ld_cnt == LAST_ADDR)) w_next = SERVE;
            SERVE:   if (finish) w_next = DUMP;
            DUMP:    if (w_dp_acc && (r_dp_cnt == LAST_ADDR)) w_next = DONE;
            DONE:    w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Counters wrap to 0 after the last pixel, so a reload or re-dump
    // always starts at address 0 without an explicit clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_cnt <= '0;
            r_dp_cnt <= '0;
        end else begin
            if (w_ld_acc) r_ld_cnt <= r_ld_cnt + 1'b1;
            if (w_dp_acc) r_dp_cnt <= r_dp_cnt + 1'b1;
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        gray_ready = 1'b0;
        gray_data  = '0;
        out_valid  = 1'b0;
        out_addr   = '0;
        out_data   = '0;
        done       = 1'b0;
        case (r_state)
            LOAD: in_ready = 1'b1;
            SERVE: begin
                gray_ready = 1'b1;
                gray_data  = w_gray_rdata;
            end
            DUMP: begin
                out_valid = 1'b1;
                out_addr  = r_dp_cnt;
`ifdef LBP_BORDER_CLEAR_EN
                out_data  = is_border(r_dp_cnt) ? '0 : w_lbp_rdata;
`else
                out_data  = w_lbp_rdata;
`endif
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lbp_host_mem.sv
module tb_lbp_host_mem;
    import lbp_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          gray_ready;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [DW-1:0] lbp_data;
    logic          finish;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          done;

    lbp_host_mem dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .gray_ready (gray_ready),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          c;
    } exp_t;

    exp_t          sb[$];
    int            beat_cnt = 0;
    logic [DW-1:0] lbp_exp [NPIX];
    bit            lbp_known [NPIX];
    int            acc_cyc [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int i, input int seed);
        return DW'(i * 7 + (i >> 7) + seed);
    endfunction

    function automatic bit border_addr(input int a);
        int row, col;
        row = a / IMG_W;
        col = a % IMG_W;
        return (row == 0) || (row == IMG_H - 1) || (col == 0) || (col == IMG_W - 1);
    endfunction

    function automatic logic [DW-1:0] exp_out(input int a);
`ifdef LBP_BORDER_CLEAR_EN
        if (border_addr(a)) return '0;
`endif
        return lbp_exp[a];
    endfunction

    function automatic bit exp_known(input int a);
`ifdef LBP_BORDER_CLEAR_EN
        if (border_addr(a)) return 1'b1;
`endif
        return lbp_known[a];
    endfunction

    // Scoreboard monitor: every accepted beat pops one expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_unexpected: got beat at addr %0d, expected no beat", out_addr);
            end else begin
                e = sb.pop_front();
                chk("beat_addr", 32'(out_addr), 32'(e.a));
                if (e.c) chk("beat_data", 32'(out_data), 32'(e.d));
            end
            if (out_addr < 6) acc_cyc[out_addr] = cyc;
            beat_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int seed, input bit toggle);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            in_valid = 1'b1;
            in_data  = pix(i, seed);
            if (i == 0) begin
                @(negedge clk);
                chk("in_ready_load", 32'(in_ready), 32'd1);
            end
            if (i == NPIX - 1) begin
                @(negedge clk);
                chk("gray_ready_before_last", 32'(gray_ready), 32'd0);
            end
            tick();
            in_valid = 1'b0;
            if (i == NPIX - 1) chk("gray_ready_after_last", 32'(gray_ready), 32'd1);
            if (toggle) tick();
        end
    endtask

    task automatic lbp_write(input int a, input logic [DW-1:0] d);
        lbp_valid = 1'b1;
        lbp_addr  = AW'(a);
        lbp_data  = d;
        tick();
        lbp_valid    = 1'b0;
        lbp_exp[a]   = d;
        lbp_known[a] = 1'b1;
    endtask

    task automatic push_dump(input int n);
        exp_t e;
        for (int a = 0; a < n; a++) begin
            e.a = AW'(a);
            e.d = exp_out(a);
            e.c = exp_known(a);
            sb.push_back(e);
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beat_cnt < n && k < budget) begin
            tick();
            k++;
        end
        if (beat_cnt < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_beats_timeout: got %0d beats, expected %0d", beat_cnt, n);
        end
    endtask

    task automatic gray_read_chk(input int a, input int seed);
        gray_addr = AW'(a);
        #1;
        chk("gray_data", 32'(gray_data), 32'(pix(a, seed)));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        gray_addr = '0;
        lbp_valid = 1'b0;
        lbp_addr  = '0;
        lbp_data  = '0;
        finish    = 1'b0;
        out_ready = 1'b0;
        for (int a = 0; a < NPIX; a++) begin
            lbp_exp[a]   = '0;
            lbp_known[a] = 1'b0;
        end
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_gray_ready", 32'(gray_ready), 32'd0);
        chk("rst_gray_data",  32'(gray_data),  32'd0);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_addr",   32'(out_addr),   32'd0);
        chk("rst_out_data",   32'(out_data),   32'd0);
        chk("rst_done",       32'(done),       32'd0);
        reset = 1'b0;
        tick();

        // First pass: toggled load, serve, partial dump, reset mid-dump.
        load_image(3, 1'b1);
        gray_read_chk(129, 3);
        gray_read_chk(0, 3);
        gray_read_chk(NPIX - 1, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_serve", 32'(gray_ready), 32'd1);
        for (int a = 0; a < 200; a++)
            lbp_write(a, (a == 0) ? 8'hFF : DW'(a * 3 + 1));
        lbp_write(250, 8'h11);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("dump_gray_ready", 32'(gray_ready), 32'd0);
        beat_cnt = 0;
        push_dump(100);
        out_ready = 1'b1;
        lbp_valid = 1'b1;
        lbp_addr  = AW'(250);
        lbp_data  = 8'h77;
        wait_beats(100, 400);
        out_ready = 1'b0;
        lbp_valid = 1'b0;
        chk("mid_dump_addr", 32'(out_addr), 32'd100);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid",  32'(out_valid),  32'd0);
        chk("mid_rst_gray_ready", 32'(gray_ready), 32'd0);
        chk("mid_rst_done",       32'(done),       32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Second pass: continuous load, write+finish together, full dump with stall.
        lbp_valid = 1'b1;
        lbp_addr  = AW'(250);
        lbp_data  = 8'h88;
        load_image(9, 1'b0);
        lbp_valid = 1'b0;
        gray_read_chk(129, 9);
        lbp_write(4, 8'h5A);
        lbp_valid = 1'b1;
        lbp_addr  = AW'(16254);
        lbp_data  = 8'hA5;
        finish    = 1'b1;
        tick();
        lbp_valid = 1'b0;
        finish    = 1'b0;
        lbp_exp[16254]   = 8'hA5;
        lbp_known[16254] = 1'b1;
        beat_cnt = 0;
        push_dump(NPIX);
        out_ready = 1'b1;
        wait_beats(3, 50);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_addr",  32'(out_addr),  32'd3);
            chk("stall_data",  32'(out_data),  32'(exp_out(3)));
            tick();
        end
        out_ready = 1'b1;
        wait_beats(NPIX, NPIX + 100);
        out_ready = 1'b0;
        chk("done_out_valid", 32'(out_valid), 32'd0);
        chk("done_flag",      32'(done),      32'd1);
        chk("consec_3_4", 32'(acc_cyc[4] - acc_cyc[3]), 32'd1);
        chk("consec_4_5", 32'(acc_cyc[5] - acc_cyc[4]), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        chk("done_sticky",       32'(done),     32'd1);
        chk("done_start_ignore", 32'(in_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
